// File: rtl/pix_filter_pipe.sv
// Two-stage pixel filter pipeline: S1 forms the weighted luma sum, S2 applies
// the selected filter. Config is latched on start-of-frame pixels only.
module pix_filter_pipe #(
    parameter int CW     = 4,
    parameter int WR     = 8,
    parameter int WG     = 16,
    parameter int WB     = 1,
    parameter int WSHIFT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic [CW-1:0]     thresh,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic [3*CW-1:0]   pix_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic [3*CW-1:0]   pix_out
);

    localparam int PW = 3 * CW;
    localparam int SW = CW + $clog2(WR + WG + WB + 1);

    localparam logic [SW-1:0] WR_S = SW'(WR);
    localparam logic [SW-1:0] WG_S = SW'(WG);
    localparam logic [SW-1:0] WB_S = SW'(WB);
    localparam logic [SW-1:0] YMAX = SW'((1 << CW) - 1);

    typedef enum logic [1:0] {
        M_PASS = 2'd0,
        M_GREY = 2'd1,
        M_INV  = 2'd2,
        M_THR  = 2'd3
    } mode_t;

    // Held configuration, replaced only by an accepted sof pixel
    mode_t          cfg_mode;
    logic [CW-1:0]  cfg_thresh;

    logic           s1_valid;
    logic           s1_sof;
    logic [PW-1:0]  s1_pix;
    logic [SW-1:0]  s1_sum;
    mode_t          s1_mode;
    logic [CW-1:0]  s1_thresh;

    logic           s2_valid;
    logic           s2_sof;
    logic [PW-1:0]  s2_pix;

    logic           advance;
    logic           s1_load;
    logic           accept;

    mode_t          eff_mode;
    logic [CW-1:0]  eff_thresh;
    logic [SW-1:0]  in_sum;
    logic [SW-1:0]  ch_r;
    logic [SW-1:0]  ch_g;
    logic [SW-1:0]  ch_b;

    logic [SW-1:0]  y_shift;
    logic [CW-1:0]  y_sat;
    logic [PW-1:0]  filt_pix;

    // S1 may still fill a bubble while S2 is stalled
    assign advance  = !s2_valid || out_ready;
    assign s1_load  = advance || !s1_valid;
    assign in_ready = !s1_valid || advance;
    assign accept   = in_valid && in_ready;

    assign out_valid = s2_valid;
    assign out_sof   = s2_sof;
    assign pix_out   = s2_pix;

    always_comb begin
        eff_mode   = cfg_mode;
        eff_thresh = cfg_thresh;
        if (in_sof) begin
            eff_mode   = mode_t'(mode);
            eff_thresh = thresh;
        end
    end

    always_comb begin
        ch_r   = SW'(pix_in[PW-1 -: CW]);
        ch_g   = SW'(pix_in[2*CW-1 -: CW]);
        ch_b   = SW'(pix_in[CW-1:0]);
        in_sum = (WR_S * ch_r) + (WG_S * ch_g) + (WB_S * ch_b);
    end

    always_comb begin
        y_shift = s1_sum >> WSHIFT;
        y_sat   = (y_shift > YMAX) ? {CW{1'b1}} : y_shift[CW-1:0];
    end

    always_comb begin
        filt_pix = s1_pix;
        unique case (s1_mode)
            M_PASS: filt_pix = s1_pix;
            M_GREY: filt_pix = {y_sat, y_sat, y_sat};
            M_INV:  filt_pix = ~s1_pix;
            M_THR:  filt_pix = (y_sat >= s1_thresh) ? {PW{1'b1}} : {PW{1'b0}};
            default: filt_pix = s1_pix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_mode   <= M_PASS;
            cfg_thresh <= '0;
        end else if (accept && in_sof) begin
            cfg_mode   <= mode_t'(mode);
            cfg_thresh <= thresh;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sof    <= 1'b0;
            s1_pix    <= '0;
            s1_sum    <= '0;
            s1_mode   <= M_PASS;
            s1_thresh <= '0;
        end else if (s1_load) begin
            s1_valid  <= in_valid;
            s1_sof    <= in_sof;
            s1_pix    <= pix_in;
            s1_sum    <= in_sum;
            s1_mode   <= eff_mode;
            s1_thresh <= eff_thresh;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sof   <= 1'b0;
            s2_pix   <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_sof   <= s1_sof;
            s2_pix   <= filt_pix;
        end
    end

endmodule

// File: tb/tb_pix_filter_pipe.sv
// Bench for pix_filter_pipe: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_pix_filter_pipe;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mode;
    logic [3:0]  thresh;
    logic        in_valid;
    logic        in_ready;
    logic        in_sof;
    logic [11:0] pix_in;
    logic        out_valid;
    logic        out_ready;
    logic        out_sof;
    logic [11:0] pix_out;

    pix_filter_pipe dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .thresh(thresh),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .pix_in(pix_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof), .pix_out(pix_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pop_cnt = 0;

    typedef struct packed {
        logic [11:0] pix;
        logic        sof;
    } exp_t;

    exp_t        exp_q[$];
    logic [1:0]  m_mode = 2'd0;
    logic [3:0]  m_thr  = 4'd0;
    logic        hold_v = 1'b0;
    logic [11:0] hold_pix = 12'h0;
    logic        hold_sof = 1'b0;

    task automatic check(input string name, input logic ok, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    // Luma Y = min(floor((8R + 16G + B) / 16), 15)
    function automatic logic [11:0] model(input logic [11:0] px, input logic [1:0] md, input logic [3:0] th);
        int r, g, b, y;
        r = int'(px[11:8]);
        g = int'(px[7:4]);
        b = int'(px[3:0]);
        y = (8 * r + 16 * g + b) / 16;
        if (y > 15) y = 15;
        case (md)
            2'd0:    return px;
            2'd1:    return {y[3:0], y[3:0], y[3:0]};
            2'd2:    return ~px;
            default: return (y >= int'(th)) ? 12'hFFF : 12'h000;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_mode = 2'd0;
            m_thr  = 4'd0;
            hold_v = 1'b0;
        end else begin
            if (hold_v)
                check("stall_hold", out_valid && pix_out == hold_pix && out_sof == hold_sof,
                      {19'd0, out_valid, pix_out}, {19'd0, 1'b1, hold_pix});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 1'b0, {20'd0, pix_out}, 32'd0);
                end else begin
                    check("model_pix", pix_out == exp_q[0].pix, {20'd0, pix_out}, {20'd0, exp_q[0].pix});
                    check("model_sof", out_sof == exp_q[0].sof, {31'd0, out_sof}, {31'd0, exp_q[0].sof});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        pop_cnt++;
                    end
                end
            end
            hold_v   = out_valid && !out_ready;
            hold_pix = pix_out;
            hold_sof = out_sof;
            if (in_valid && in_ready) begin
                if (in_sof) begin
                    m_mode = mode;
                    m_thr  = thresh;
                end
                exp_q.push_back('{pix: model(pix_in, m_mode, m_thr), sof: in_sof});
            end
        end
    end

    task automatic send(input logic sof, input logic [1:0] md, input logic [3:0] th, input logic [11:0] px);
        int n;
        logic acc;
        n = 0;
        acc = 1'b0;
        in_valid = 1'b1; in_sof = sof; mode = md; thresh = th; pix_in = px;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("send_timeout", 1'b0, 32'd0, 32'd1);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    // Single pixel into an empty pipe with out_ready high; checks exact latency and value
    task automatic one(input string name, input logic sof, input logic [1:0] md, input logic [3:0] th,
                       input logic [11:0] px, input logic [11:0] expv);
        in_valid = 1'b1; in_sof = sof; mode = md; thresh = th; pix_in = px;
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0;
        check({name, "_lat"}, out_valid == 1'b0, {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check({name, "_valid"}, out_valid == 1'b1, {31'd0, out_valid}, 32'd1);
        check({name, "_pix"}, pix_out == expv, {20'd0, pix_out}, {20'd0, expv});
        check({name, "_sof"}, out_sof == sof, {31'd0, out_sof}, {31'd0, sof});
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", exp_q.size() == 0 && !out_valid, exp_q.size(), 32'd0);
    endtask

    logic stream_done;

    initial begin
        int pops_before;
        rst_n = 1'b0; mode = 2'd0; thresh = 4'd0; in_valid = 1'b0; in_sof = 1'b0;
        pix_in = 12'h0; out_ready = 1'b1; stream_done = 1'b0;
        #12;
        check("rst_out_valid", out_valid == 1'b0, {31'd0, out_valid}, 32'd0);
        check("rst_out_sof", out_sof == 1'b0, {31'd0, out_sof}, 32'd0);
        check("rst_pix_out", pix_out == 12'h000, {20'd0, pix_out}, 32'd0);
        check("rst_in_ready", in_ready == 1'b1, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        one("grey_234", 1'b1, 2'd1, 4'd0, 12'h234, 12'h444);
        one("grey_sat", 1'b0, 2'd1, 4'd0, 12'hFFF, 12'hFFF);
        one("grey_zero", 1'b0, 2'd1, 4'd0, 12'h000, 12'h000);
        one("inv_123", 1'b1, 2'd2, 4'd0, 12'h123, 12'hEDC);
        one("thr_eq", 1'b1, 2'd3, 4'd8, 12'h080, 12'hFFF);
        one("thr_below", 1'b0, 2'd3, 4'd8, 12'h070, 12'h000);

        one("mid_grey", 1'b1, 2'd1, 4'd0, 12'h234, 12'h444);
        one("mid_nosof", 1'b0, 2'd2, 4'd0, 12'h234, 12'h444);
        one("mid_sof_inv", 1'b1, 2'd2, 4'd0, 12'h234, 12'hDCB);
        one("mid_after", 1'b0, 2'd0, 4'd0, 12'h234, 12'hDCB);

        pops_before = pop_cnt;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    logic [1:0] md;
                    md = (i < 8) ? 2'd1 : 2'd3;
                    if (i % 8 != 0) md = 2'(i);
                    send(i % 8 == 0, md, 4'd6, 12'($urandom_range(0, 4095)));
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();
        check("stream_count", pop_cnt - pops_before == 16, pop_cnt - pops_before, 32'd16);

        out_ready = 1'b0;
        send(1'b0, 2'd1, 4'd0, 12'h111);
        send(1'b0, 2'd1, 4'd0, 12'h222);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid == 1'b0, {31'd0, out_valid}, 32'd0);
        check("mid_rst_sof", out_sof == 1'b0, {31'd0, out_sof}, 32'd0);
        check("mid_rst_in_ready", in_ready == 1'b1, {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("no_stale", out_valid == 1'b0, {31'd0, out_valid}, 32'd0);
        end
        one("post_rst_pass", 1'b0, 2'd1, 4'd0, 12'h5A3, 12'h5A3);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
